mem_stage_ls: RTL and testbench
===============================

// Module: mem_stage_ls
// PURPOSE
//   Next-generation MEM pipeline stage. Sits between EX/MEM and MEM/WB: forwards GPR and HI/LO
//   write-back, executes LB/LBU/LH/LHU/LW/SB/SH/SW over a req/ack data bus, stalls upstream
//   while a bus access is pending, flags misaligned accesses, and times out on a missing ack.
//   All WB-side outputs are registered: this stage absorbs the MEM/WB pipeline register.
// PARAMETERS
//   DATA_W     32  data width; fixed at 32 (byte lanes = 4)
//   ADDR_W     32  bus address width
//   REGA_W     5   GPR address width
//   TIMEOUT    16  max ACCESS cycles without bus_ack_i before bus error (>=1)
// PORTS
//   clk          in   1        clock, rising edge
//   rst          in   1        reset, synchronous, active-high
//   valid_i      in   1        EX/MEM holds a valid instruction
//   wd_i         in   REGA_W   GPR destination
//   wreg_i       in   1        GPR write enable
//   wdata_i      in   DATA_W   ALU result
//   hi_i/lo_i    in   DATA_W   HI/LO write data
//   whilo_i      in   1        HI/LO write enable
//   mem_op_i     in   4        0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW; others = NONE
//   mem_addr_i   in   ADDR_W   effective byte address
//   mem_sdata_i  in   DATA_W   store data
//   stall_o      out  1        upstream must hold all *_i stable
//   bus_req_o    out  1        bus request (registered)
//   bus_we_o     out  1        1 = store
//   bus_addr_o   out  ADDR_W   word address, bits [1:0] = 0
//   bus_be_o     out  4        byte enables, lane n = bits [8n+7:8n], little-endian
//   bus_wdata_o  out  DATA_W   store data, lane-replicated
//   bus_ack_i    in   1        one-cycle completion; bus_rdata_i valid in same cycle
//   bus_rdata_i  in   DATA_W   load data
//   valid_o, wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  to WB (registered)
//   excp_align_o out  1        one-cycle pulse: misaligned access
//   excp_bus_o   out  1        one-cycle pulse: bus timeout
// BEHAVIOUR
//   Reset: every output, FSM (IDLE) and timeout counter to 0, synchronously, including mid-access.
//   Non-memory op (valid_i, NONE): 1-cycle latency; WB regs <= inputs, valid_o=1, stall_o=0.
//     whilo_o/wreg_o are gated by valid_i; valid_i=0 loads valid_o=wreg_o=whilo_o=0.
//   Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. No bus access, stall_o=0;
//     next cycle valid_o=1, excp_align_o=1, wreg_o=0, whilo_o=0.
//   FSM IDLE->ACCESS: valid aligned mem op in IDLE; stall_o=1 combinationally that cycle;
//     next edge registers bus_req_o=1, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o; counter=0.
//   ACCESS: bus outputs held constant; stall_o = !bus_ack_i; counter increments per cycle.
//     bus_ack_i=1 -> IDLE; next cycle bus_req_o=0, valid_o=1, wd_o/wreg_o from inputs,
//     wdata_o = extended load data (load) or wdata_i (store). Best-case load latency: 2 cycles.
//     counter reaches TIMEOUT-1 without ack -> IDLE, stall_o=0 that cycle, next cycle
//     bus_req_o=0, valid_o=1, excp_bus_o=1, wreg_o=0, whilo_o=0. Ack in the final cycle wins.
//   Byte enables: B 4'b0001<<a[1:0]; H a[1]?4'b1100:4'b0011; W 4'b1111.
//   Store data: SB {4{s[7:0]}}; SH {2{s[15:0]}}; SW s.
//   Load extract: selected lane(s) right-justified; LB/LH sign-extend, LBU/LHU zero-extend.
//   No new op accepted in ACCESS; bus_ack_i outside ACCESS is ignored.
//   HI/LO pass through with same latency as wdata_o.
// TESTING
//   T1 ALU: wd_i=5, wreg_i=1, wdata_i=0x1234, whilo_i=1, hi_i=0xA -> next cycle
//      wd_o=5, wdata_o=0x1234, hi_o=0xA, whilo_o=1, stall_o stays 0.
//   T2 LB addr 0x1003, ack after 2 wait cycles, rdata 0x80FF_FF01 -> bus_addr_o=0x1000,
//      be=1000, stall_o=1 for 3 cycles, wdata_o=0xFFFF_FF80; repeat LBU -> 0x0000_0080.
//   T3 SH addr 0x2002, sdata 0xAAAA_BEEF, immediate ack -> bus_we_o=1, be=1100,
//      bus_wdata_o=0xBEEF_BEEF, valid_o 2 cycles after accept.
//   T4 LW addr 0x1001 -> no bus_req_o, next cycle excp_align_o=1, wreg_o=0, stall_o=0.
//   T5 TIMEOUT=4, LW no ack -> req high 4 cycles, then excp_bus_o=1, bus_req_o=0.
//   T6 rst asserted in 2nd ACCESS cycle -> next edge all outputs 0, FSM IDLE; later ack ignored.

Source files
------------

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage with load/store bus unit and MEM/WB register.
//   Forwards GPR and HI/LO write-back to WB one cycle after acceptance, executes
//   LB/LBU/LH/LHU/LW/SB/SH/SW over a single-outstanding req/ack bus, stalls the
//   upstream stages while an access is pending, and raises one-cycle exception
//   pulses for misaligned accesses and for a bus that never acknowledges.
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   valid_i .. mem_sdata_i   EX/MEM payload (held stable by upstream while stall_o=1)
//   stall_o                  combinational: upstream must hold all inputs
//   bus_req_o .. bus_wdata_o registered bus request, held constant during an access
//   bus_ack_i, bus_rdata_i   one-cycle completion with load data
//   valid_o .. whilo_o       registered write-back payload
//   excp_align_o, excp_bus_o registered one-cycle exception pulses
module mem_stage_ls #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned REGA_W  = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [REGA_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              whilo_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_sdata_i,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              valid_o,
    output logic [REGA_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              excp_align_o,
    output logic              excp_bus_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;

    logic              bus_req_d, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [3:0]        bus_be_d;
    logic [DATA_W-1:0] bus_wdata_d;
    logic              valid_d, wreg_d, whilo_d;
    logic [REGA_W-1:0] wd_d;
    logic [DATA_W-1:0] wdata_d, hi_d, lo_d;
    logic              excp_align_d, excp_bus_d;

    // Request decode of the incoming operation
    logic              is_byte, is_half, is_word, is_store, is_mem, misaligned;
    logic [3:0]        req_be;
    logic [DATA_W-1:0] req_sdata;

    always_comb begin
        is_byte    = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
        is_half    = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
        is_word    = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        is_store   = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
        is_mem     = is_byte || is_half || is_word;
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
        req_be     = 4'b1111;
        req_sdata  = mem_sdata_i;
        if (is_byte) begin
            req_be    = 4'b0001 << mem_addr_i[1:0];
            req_sdata = {4{mem_sdata_i[7:0]}};
        end else if (is_half) begin
            req_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            req_sdata = {2{mem_sdata_i[15:0]}};
        end
    end

    // Load data extraction, using the op and byte offset captured at acceptance
    logic [DATA_W-1:0] rd_shift, load_data;
    logic              op_is_load;

    always_comb begin
        rd_shift   = bus_rdata_i >> {off_q, 3'b000};
        op_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
        load_data  = bus_rdata_i;
        case (op_q)
            OP_LB:   load_data = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, rd_shift[7:0]};
            OP_LH:   load_data = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
            OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, rd_shift[15:0]};
            default: load_data = bus_rdata_i;
        endcase
    end

    // Next-state, stall and next values of every registered output
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        off_d        = off_q;
        stall_o      = 1'b0;
        bus_req_d    = bus_req_o;
        bus_we_d     = bus_we_o;
        bus_addr_d   = bus_addr_o;
        bus_be_d     = bus_be_o;
        bus_wdata_d  = bus_wdata_o;
        valid_d      = 1'b0;
        wd_d         = wd_i;
        wreg_d       = 1'b0;
        wdata_d      = wdata_i;
        hi_d         = hi_i;
        lo_d         = lo_i;
        whilo_d      = 1'b0;
        excp_align_d = 1'b0;
        excp_bus_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        wreg_d  = wreg_i;
                        whilo_d = whilo_i;
                    end else if (misaligned) begin
                        valid_d      = 1'b1;
                        excp_align_d = 1'b1;
                    end else begin
                        stall_o     = 1'b1;
                        state_d     = S_ACCESS;
                        cnt_d       = '0;
                        op_d        = mem_op_i;
                        off_d       = mem_addr_i[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store;
                        bus_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_sdata;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the last allowed cycle completes normally
                if (bus_ack_i) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    valid_d   = 1'b1;
                    wreg_d    = wreg_i && valid_i;
                    whilo_d   = whilo_i && valid_i;
                    wdata_d   = op_is_load ? load_data : wdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_IDLE;
                    bus_req_d  = 1'b0;
                    valid_d    = 1'b1;
                    excp_bus_d = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            off_q        <= '0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_be_o     <= '0;
            bus_wdata_o  <= '0;
            valid_o      <= 1'b0;
            wd_o         <= '0;
            wreg_o       <= 1'b0;
            wdata_o      <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
            whilo_o      <= 1'b0;
            excp_align_o <= 1'b0;
            excp_bus_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            off_q        <= off_d;
            bus_req_o    <= bus_req_d;
            bus_we_o     <= bus_we_d;
            bus_addr_o   <= bus_addr_d;
            bus_be_o     <= bus_be_d;
            bus_wdata_o  <= bus_wdata_d;
            valid_o      <= valid_d;
            wd_o         <= wd_d;
            wreg_o       <= wreg_d;
            wdata_o      <= wdata_d;
            hi_o         <= hi_d;
            lo_o         <= lo_d;
            whilo_o      <= whilo_d;
            excp_align_o <= excp_align_d;
            excp_bus_o   <= excp_bus_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: directed self-checking bench for mem_stage_ls (TIMEOUT=4).
module tb_mem_stage_ls;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_sdata_i;
    logic        stall_o, bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, excp_align_o, excp_bus_o;

    int checks = 0;
    int failures = 0;

    mem_stage_ls #(.DATA_W(32), .ADDR_W(32), .REGA_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .valid_o(valid_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .excp_align_o(excp_align_o), .excp_bus_o(excp_bus_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one aligned access, acks it after 'waits' ACCESS cycles, and
    // returns the number of stall cycles plus the bus request seen in ACCESS.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input int waits,
                              input logic [31:0] rdata, output int stalls,
                              output logic req, output logic we,
                              output logic [31:0] baddr, output logic [3:0] be,
                              output logic [31:0] bwdata);
        valid_i     = 1'b1;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        stalls      = 0;
        #1;
        if (stall_o) stalls++;
        tick();
        req    = bus_req_o;
        we     = bus_we_o;
        baddr  = bus_addr_o;
        be     = bus_be_o;
        bwdata = bus_wdata_o;
        for (int i = 0; i < waits; i++) begin
            if (stall_o) stalls++;
            tick();
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        #1;
        if (stall_o) stalls++;
        tick();
        bus_ack_i = 1'b0;
        valid_i   = 1'b0;
        mem_op_i  = 4'd0;
    endtask

    int          st;
    logic        rq, we;
    logic [31:0] ba, bw;
    logic [3:0]  be;

    initial begin
        rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        hi_i = '0; lo_i = '0; whilo_i = 1'b0; mem_op_i = '0; mem_addr_i = '0;
        mem_sdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        tick(); tick();
        check("rst valid_o", 32'(valid_o), 32'd0);
        check("rst bus_req_o", 32'(bus_req_o), 32'd0);
        check("rst stall_o", 32'(stall_o), 32'd0);
        check("rst wdata_o", wdata_o, 32'd0);
        rst = 1'b0;

        // T1: plain ALU forward
        valid_i = 1'b1; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
        whilo_i = 1'b1; hi_i = 32'hA; lo_i = 32'hB;
        #1;
        check("t1 stall_o", 32'(stall_o), 32'd0);
        tick();
        check("t1 valid_o", 32'(valid_o), 32'd1);
        check("t1 wd_o", 32'(wd_o), 32'd5);
        check("t1 wdata_o", wdata_o, 32'h1234);
        check("t1 hi_o", hi_o, 32'hA);
        check("t1 lo_o", lo_o, 32'hB);
        check("t1 whilo_o", 32'(whilo_o), 32'd1);
        check("t1 wreg_o", 32'(wreg_o), 32'd1);
        valid_i = 1'b0;
        tick();
        check("t1 bubble valid_o", 32'(valid_o), 32'd0);
        check("t1 bubble wreg_o", 32'(wreg_o), 32'd0);
        check("t1 bubble whilo_o", 32'(whilo_o), 32'd0);

        // T2: loads with 2 wait cycles
        wd_i = 5'd7; wreg_i = 1'b1; whilo_i = 1'b0; wdata_i = 32'hDEAD;
        run_access(4'd1, 32'h1003, 32'h0, 2, 32'h80FF_FF01, st, rq, we, ba, be, bw);
        check("t2 lb stalls", 32'(st), 32'd3);
        check("t2 lb req", 32'(rq), 32'd1);
        check("t2 lb we", 32'(we), 32'd0);
        check("t2 lb addr", ba, 32'h1000);
        check("t2 lb be", 32'(be), 32'h8);
        check("t2 lb valid_o", 32'(valid_o), 32'd1);
        check("t2 lb wdata_o", wdata_o, 32'hFFFF_FF80);
        check("t2 lb wd_o", 32'(wd_o), 32'd7);
        check("t2 lb wreg_o", 32'(wreg_o), 32'd1);
        check("t2 lb req after", 32'(bus_req_o), 32'd0);
        run_access(4'd2, 32'h1003, 32'h0, 2, 32'h80FF_FF01, st, rq, we, ba, be, bw);
        check("t2 lbu stalls", 32'(st), 32'd3);
        check("t2 lbu wdata_o", wdata_o, 32'h0000_0080);
        run_access(4'd3, 32'h1002, 32'h0, 0, 32'h80FF_FF01, st, rq, we, ba, be, bw);
        check("lh be", 32'(be), 32'hC);
        check("lh wdata_o", wdata_o, 32'hFFFF_80FF);
        run_access(4'd4, 32'h1000, 32'h0, 1, 32'h80FF_FF01, st, rq, we, ba, be, bw);
        check("lhu be", 32'(be), 32'h3);
        check("lhu wdata_o", wdata_o, 32'h0000_FF01);
        run_access(4'd5, 32'h1004, 32'h0, 0, 32'h1234_5678, st, rq, we, ba, be, bw);
        check("lw addr", ba, 32'h1004);
        check("lw be", 32'(be), 32'hF);
        check("lw wdata_o", wdata_o, 32'h1234_5678);

        // T3: stores, immediate ack
        wdata_i = 32'h55; wreg_i = 1'b0;
        run_access(4'd7, 32'h2002, 32'hAAAA_BEEF, 0, 32'hFFFF_FFFF, st, rq, we, ba, be, bw);
        check("t3 sh stalls", 32'(st), 32'd1);
        check("t3 sh we", 32'(we), 32'd1);
        check("t3 sh addr", ba, 32'h2000);
        check("t3 sh be", 32'(be), 32'hC);
        check("t3 sh bus_wdata", bw, 32'hBEEF_BEEF);
        check("t3 sh valid_o", 32'(valid_o), 32'd1);
        check("t3 sh wdata_o", wdata_o, 32'h55);
        run_access(4'd6, 32'h3001, 32'h1234_56A5, 0, 32'h0, st, rq, we, ba, be, bw);
        check("sb be", 32'(be), 32'h2);
        check("sb bus_wdata", bw, 32'hA5A5_A5A5);
        run_access(4'd8, 32'h3008, 32'hCAFE_F00D, 0, 32'h0, st, rq, we, ba, be, bw);
        check("sw be", 32'(be), 32'hF);
        check("sw bus_wdata", bw, 32'hCAFE_F00D);

        // T4: misaligned LW
        tick();
        valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h1001; wreg_i = 1'b1; whilo_i = 1'b1;
        #1;
        check("t4 stall_o", 32'(stall_o), 32'd0);
        tick();
        check("t4 bus_req_o", 32'(bus_req_o), 32'd0);
        check("t4 excp_align_o", 32'(excp_align_o), 32'd1);
        check("t4 valid_o", 32'(valid_o), 32'd1);
        check("t4 wreg_o", 32'(wreg_o), 32'd0);
        check("t4 whilo_o", 32'(whilo_o), 32'd0);
        valid_i = 1'b0;
        tick();
        check("t4 align pulse", 32'(excp_align_o), 32'd0);

        // T5: timeout after 4 ACCESS cycles
        valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h4000;
        #1;
        check("t5 accept stall", 32'(stall_o), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t5 req", 32'(bus_req_o), 32'd1);
            check("t5 stall", 32'(stall_o), (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        valid_i = 1'b0;
        check("t5 req dropped", 32'(bus_req_o), 32'd0);
        check("t5 excp_bus_o", 32'(excp_bus_o), 32'd1);
        check("t5 valid_o", 32'(valid_o), 32'd1);
        check("t5 wreg_o", 32'(wreg_o), 32'd0);
        tick();
        check("t5 bus pulse", 32'(excp_bus_o), 32'd0);

        // T6: reset during the second ACCESS cycle
        valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h5000;
        tick();
        tick();
        check("t6 in access", 32'(bus_req_o), 32'd1);
        rst = 1'b1; valid_i = 1'b0; mem_op_i = 4'd0;
        tick();
        check("t6 rst req", 32'(bus_req_o), 32'd0);
        check("t6 rst be", 32'(bus_be_o), 32'd0);
        check("t6 rst addr", bus_addr_o, 32'd0);
        check("t6 rst valid_o", 32'(valid_o), 32'd0);
        check("t6 rst stall_o", 32'(stall_o), 32'd0);
        rst = 1'b0;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        tick();
        bus_ack_i = 1'b0;
        check("t6 late ack valid_o", 32'(valid_o), 32'd0);
        check("t6 late ack wreg_o", 32'(wreg_o), 32'd0);
        check("t6 late ack req", 32'(bus_req_o), 32'd0);
        check("t6 late ack excp", 32'(excp_bus_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
